// File: rtl/gs_sweep_scheduler.sv
// gs_sweep_scheduler: runs an 8-row Gauss-Seidel solve on one external row core.
// Holds the coefficient rows and the solution vector, issues rows in order,
// writes each result back in place, then streams the 8 solution words out.
module gs_sweep_scheduler #(
  parameter int N_ITER  = 16,
  parameter int TIMEOUT = 63
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_row_valid,
  output logic         o_row_ready,
  input  logic [55:0]  i_row_a,
  input  logic [7:0]   i_row_b,
  input  logic [31:0]  i_row_adown,
  output logic         core_clear,
  output logic         core_valid,
  output logic [55:0]  core_a,
  output logic [7:0]   core_b,
  output logic [31:0]  core_adown,
  output logic [223:0] core_x,
  input  logic         core_done,
  input  logic [31:0]  core_xnext,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [31:0]  o_x,
  output logic [2:0]   o_idx,
  output logic         o_busy,
  output logic         o_error
);

  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     row_cnt_q, row_cnt_d;
  logic [2:0]     k_q, k_d;
  logic [7:0]     sweep_q, sweep_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [2:0]     idx_q, idx_d;
  logic           error_q, error_d;
  logic [31:0]    x_q [8];
  logic [31:0]    x_d [8];
  logic [55:0]    core_a_q, core_a_d;
  logic [7:0]     core_b_q, core_b_d;
  logic [31:0]    core_adown_q, core_adown_d;
  logic [223:0]   core_x_q, core_x_d;

  // Row store; only written during LOAD, read once per row when staging it
  logic [55:0]    mem_a     [8];
  logic [7:0]     mem_b     [8];
  logic [31:0]    mem_adown [8];

  // x values seen by row k: every x except x[k], in ascending index order
  logic [31:0]    x_sel [7];
  logic           load_fire;

  assign load_fire = i_row_valid && (state_q == S_LOAD);

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_xsel
      assign x_sel[gi] = (3'(gi) < k_q) ? x_q[gi] : x_q[gi+1];
    end
  endgenerate

  // Capture host rows into the row store at the current row count
  always_ff @(posedge i_clk) begin
    if (load_fire) begin
      mem_a[row_cnt_q]     <= i_row_a;
      mem_b[row_cnt_q]     <= i_row_b;
      mem_adown[row_cnt_q] <= i_row_adown;
    end
  end

  // Next-state logic: load, per-row clear/issue/wait, then output streaming
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    k_d          = k_q;
    sweep_d      = sweep_q;
    tmo_d        = tmo_q;
    idx_d        = idx_q;
    error_d      = error_q;
    x_d          = x_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    core_adown_d = core_adown_q;
    core_x_d     = core_x_q;

    case (state_q)
      S_LOAD: begin
        if (i_row_valid) begin
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) begin
            for (int i = 0; i < 8; i++) x_d[i] = '0;
            k_d     = '0;
            sweep_d = '0;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        // Stage row k; x is frozen between here and ISSUE, so this snapshot
        // already contains the rows updated earlier in this sweep
        core_a_d     = mem_a[k_q];
        core_b_d     = mem_b[k_q];
        core_adown_d = mem_adown[k_q];
        core_x_d     = {x_sel[0], x_sel[1], x_sel[2], x_sel[3],
                        x_sel[4], x_sel[5], x_sel[6]};
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          x_d[k_q] = core_xnext;
          if (k_q != 3'd7) begin
            k_d     = k_q + 3'd1;
            state_d = S_CLEAR;
          end else if (int'(sweep_q) < N_ITER - 1) begin
            k_d     = '0;
            sweep_d = sweep_q + 8'd1;
            state_d = S_CLEAR;
          end else begin
            idx_d   = '0;
            state_d = S_OUT;
          end
        end else if (tmo_q == TW'(TIMEOUT)) begin
          // Core stalled: flag it and hand back whatever x holds now
          error_d = 1'b1;
          idx_d   = '0;
          state_d = S_OUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_OUT: begin
        if (i_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            row_cnt_d = '0;
            k_d       = '0;
            sweep_d   = '0;
            state_d   = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_LOAD;
      row_cnt_q    <= '0;
      k_q          <= '0;
      sweep_q      <= '0;
      tmo_q        <= '0;
      idx_q        <= '0;
      error_q      <= 1'b0;
      for (int i = 0; i < 8; i++) x_q[i] <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_adown_q <= '0;
      core_x_q     <= '0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      k_q          <= k_d;
      sweep_q      <= sweep_d;
      tmo_q        <= tmo_d;
      idx_q        <= idx_d;
      error_q      <= error_d;
      x_q          <= x_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_adown_q <= core_adown_d;
      core_x_q     <= core_x_d;
    end
  end

  assign o_row_ready = (state_q == S_LOAD);
  assign o_busy      = (state_q != S_LOAD);
  assign core_clear  = (state_q == S_CLEAR);
  assign core_valid  = (state_q == S_ISSUE);
  assign o_valid     = (state_q == S_OUT);
  assign o_x         = o_valid ? x_q[idx_q] : 32'd0;
  assign o_idx       = o_valid ? idx_q : 3'd0;
  assign o_error     = error_q;
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  assign core_adown  = core_adown_q;
  assign core_x      = core_x_q;

endmodule

// File: tb/tb_gs_sweep_scheduler.sv
// tb_gs_sweep_scheduler: scenario table plus hand sequences around a
// behavioural row core; expected issues and output words go through queues.
module tb_gs_sweep_scheduler;

  localparam int N_ITER  = 16;
  localparam int TIMEOUT = 63;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_row_valid;
  logic         o_row_ready;
  logic [55:0]  i_row_a;
  logic [7:0]   i_row_b;
  logic [31:0]  i_row_adown;
  logic         core_clear;
  logic         core_valid;
  logic [55:0]  core_a;
  logic [7:0]   core_b;
  logic [31:0]  core_adown;
  logic [223:0] core_x;
  logic         core_done = 1'b0;
  logic [31:0]  core_xnext = 32'd0;
  logic         o_valid;
  logic         i_ready;
  logic [31:0]  o_x;
  logic [2:0]   o_idx;
  logic         o_busy;
  logic         o_error;

  always #5 clk = ~clk;

  gs_sweep_scheduler #(.N_ITER(N_ITER), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_row_valid(i_row_valid), .o_row_ready(o_row_ready),
    .i_row_a(i_row_a), .i_row_b(i_row_b), .i_row_adown(i_row_adown),
    .core_clear(core_clear), .core_valid(core_valid),
    .core_a(core_a), .core_b(core_b), .core_adown(core_adown), .core_x(core_x),
    .core_done(core_done), .core_xnext(core_xnext),
    .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_idx(o_idx),
    .o_busy(o_busy), .o_error(o_error)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stand-in row arithmetic: x = (b - sum a_j*x_j) * adown, fixed-point
  function automatic logic [31:0] core_fn(input logic [55:0] a, input logic [7:0] b,
                                          input logic [31:0] d, input logic [223:0] xv);
    longint acc;
    logic signed [7:0]  aj;
    logic signed [31:0] xj;
    logic signed [7:0]  bs;
    logic signed [31:0] ds;
    bs  = b;
    ds  = d;
    acc = longint'(bs) * 64'sd16777216;
    for (int j = 0; j < 7; j++) begin
      aj  = a[55-8*j -: 8];
      xj  = xv[223-32*j -: 32];
      acc = acc - longint'(aj) * longint'(xj);
    end
    acc = ((acc >>> 6) * longint'(ds)) >>> 24;
    return acc[31:0];
  endfunction

  // Behavioural core: fixed latency after core_valid, sticky done until clear
  int          lat_cfg = 1;
  int          lat_cnt = 0;
  logic        model_busy = 1'b0;
  logic [31:0] model_res = 32'd0;
  always @(posedge clk) begin
    if (rst || core_clear) begin
      core_done  <= 1'b0;
      model_busy <= 1'b0;
    end else if (core_valid) begin
      core_done  <= 1'b0;
      model_busy <= 1'b1;
      lat_cnt    <= lat_cfg;
      model_res  <= core_fn(core_a, core_b, core_adown, core_x);
    end else if (model_busy && lat_cfg > 0) begin
      if (lat_cnt <= 1) begin
        core_done  <= 1'b1;
        core_xnext <= model_res;
        model_busy <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // Scoreboard queues and monitor counters
  logic [319:0] issue_q [$];
  logic [34:0]  out_q [$];
  logic [319:0] e_iss;
  logic [34:0]  e_out;
  logic [34:0]  held;
  int  cyc = 0;
  int  valid_cnt, clear_cnt, xfer_cnt, valid_at_out, clear_at_out, issue_cyc, out_cyc;
  bit  seen_out, stall_prev;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (core_clear) clear_cnt++;
      if (core_valid) begin
        valid_cnt++;
        issue_cyc = cyc;
        if (issue_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL issue_extra: got issue %0d, expected none", valid_cnt);
        end else begin
          e_iss = issue_q.pop_front();
          check("issue", {core_a, core_b, core_adown, core_x}, e_iss);
        end
      end
      if (o_valid) begin
        if (!seen_out) begin
          seen_out     = 1'b1;
          valid_at_out = valid_cnt;
          clear_at_out = clear_cnt;
          out_cyc      = cyc;
        end
        if (stall_prev) check("hold", 320'({o_idx, o_x}), 320'(held));
        if (i_ready) begin
          xfer_cnt++;
          $display("out idx=%0d x=%h err=%0b", o_idx, o_x, o_error);
          if (out_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL out_extra: got idx %0d, expected no word", o_idx);
          end else begin
            e_out = out_q.pop_front();
            check("out_word", 320'({o_idx, o_x}), 320'(e_out));
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held       = {o_idx, o_x};
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  logic [55:0] ra [8];
  logic [7:0]  rb [8];
  logic [31:0] rd [8];

  task automatic build_rows(input int mode);
    logic [63:0] t;
    logic [7:0]  c;
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0: begin ra[k] = '0; rb[k] = 8'(k); rd[k] = 32'h4000_0000; end
        1: begin
          t = '0;
          for (int j = 0; j < 7; j++) begin
            c = 8'((k * 7 + j * 3) % 5) - 8'd2;
            t = (t << 8) | 64'(c);
          end
          ra[k] = t[55:0];
          rb[k] = 8'(3 * k) - 8'd10;
          rd[k] = 32'h1000_0000;
        end
        default: begin
          t = {$urandom(), $urandom()};
          ra[k] = t[55:0];
          rb[k] = 8'($urandom());
          rd[k] = $urandom();
        end
      endcase
    end
  endtask

  // Reference Gauss-Seidel run: expected issue records and output words
  task automatic build_ref(input int mode, input int lat);
    logic [31:0]  xr [8];
    logic [223:0] xv;
    int src;
    issue_q.delete();
    out_q.delete();
    for (int i = 0; i < 8; i++) xr[i] = '0;
    if (lat < 0) begin
      issue_q.push_back({ra[0], rb[0], rd[0], 224'd0});
      for (int i = 0; i < 8; i++) out_q.push_back({3'(i), 32'd0});
    end else begin
      for (int sw = 0; sw < N_ITER; sw++) begin
        for (int k = 0; k < 8; k++) begin
          for (int j = 0; j < 7; j++) begin
            src = (j < k) ? j : j + 1;
            xv[223-32*j -: 32] = xr[src];
          end
          issue_q.push_back({ra[k], rb[k], rd[k], xv});
          xr[k] = core_fn(ra[k], rb[k], rd[k], xv);
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (mode == 0) out_q.push_back({3'(i), 32'(i) << 24});
        else           out_q.push_back({3'(i), xr[i]});
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_mon();
    valid_cnt = 0; clear_cnt = 0; xfer_cnt = 0;
    valid_at_out = 0; clear_at_out = 0; issue_cyc = 0; out_cyc = 0;
    seen_out = 1'b0; stall_prev = 1'b0;
  endtask

  task automatic load_rows(input bit gaps);
    for (int k = 0; k < 8; k++) begin
      i_row_valid = 1'b0;
      if (gaps) repeat (k % 3) begin @(posedge clk); #1; end
      i_row_valid = 1'b1;
      i_row_a = ra[k]; i_row_b = rb[k]; i_row_adown = rd[k];
      @(posedge clk); #1;
    end
    // A strobe right after the 8th row lands outside LOAD and must be dropped
    i_row_a = '1; i_row_b = '1; i_row_adown = '1;
    @(posedge clk); #1;
    i_row_valid = 1'b0;
  endtask

  typedef struct {
    int coef_mode;
    int lat;
    int ready_mode;
    bit gaps;
    bit pre_reset;
    bit exp_err;
    int exp_pulses;
  } scn_t;

  scn_t scn [5];

  task automatic run_scn(input scn_t s, input int id);
    int budget;
    build_rows(s.coef_mode);
    lat_cfg = s.lat;
    if (s.pre_reset) do_reset();
    build_ref(s.coef_mode, s.lat);
    clear_mon();
    mon_en = 1'b1;
    load_rows(s.gaps);
    budget = 0;
    while (xfer_cnt < 8 && budget < 6000) begin
      case (s.ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ~i_ready;
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      budget++;
    end
    i_ready = 1'b0;
    if (xfer_cnt < 8) begin
      n_vec++; n_bad++;
      $display("FAIL scn%0d_budget: got %0d transfers, expected 8", id, xfer_cnt);
    end
    @(negedge clk);
    check("back_to_load", 320'({o_row_ready, o_busy, o_valid}), 320'(3'b100));
    check("xfer_count", 320'(xfer_cnt), 320'(8));
    check("valid_pulses", 320'(valid_at_out), 320'(s.exp_pulses));
    check("clear_pulses", 320'(clear_at_out), 320'(s.exp_pulses));
    check("error_flag", 320'(o_error), 320'(s.exp_err));
    check("issue_left", 320'(issue_q.size()), 320'(0));
    if (s.lat < 0) check("timeout_cycles", 320'(out_cyc - issue_cyc), 320'(TIMEOUT + 2));
    mon_en = 1'b0;
    $display("scenario %0d done: %0d issues, error=%0b", id, valid_at_out, o_error);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    //             coef lat ready gaps prerst err pulses
    scn[0] = '{0,   1,  0,  1'b0, 1'b1, 1'b0, 128};
    scn[1] = '{1,   10, 1,  1'b1, 1'b1, 1'b0, 128};
    scn[2] = '{2,   3,  2,  1'b1, 1'b1, 1'b0, 128};
    scn[3] = '{1,   -1, 1,  1'b0, 1'b1, 1'b1, 1};
    scn[4] = '{0,   2,  1,  1'b0, 1'b0, 1'b1, 128};

    rst = 1'b1; i_row_valid = 1'b0; i_row_a = '0; i_row_b = '0; i_row_adown = '0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          320'({o_row_ready, o_busy, o_valid, core_clear, core_valid, o_error, o_idx, o_x, core_b, core_adown}),
          320'({1'b1, 80'd0}));
    check("reset_core_ax", 320'({core_a, core_x}), 320'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_scn(scn[i], i);

    // Sticky error survives a full run and only reset clears it
    do_reset();
    check("error_cleared", 320'(o_error), 320'(0));

    // Reset while waiting on the core in sweep 3
    build_rows(0);
    lat_cfg = 10;
    build_ref(0, 10);
    clear_mon();
    mon_en = 1'b1;
    load_rows(1'b0);
    budget = 0;
    while (valid_cnt < 25 && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
    end
    check("sweep3_reached", 320'(valid_cnt), 320'(25));
    check("in_wait", 320'({o_busy, core_valid, core_clear}), 320'(3'b100));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b0;
    check("mid_reset_state",
          320'({o_busy, o_row_ready, o_valid, core_valid, core_clear, o_error}),
          320'(6'b010000));
    check("mid_reset_core_x", 320'(core_x), 320'd0);
    for (int i = 0; i < 8; i++) check("mid_reset_x", 320'(dut.x_q[i]), 320'd0);
    issue_q.delete();
    out_q.delete();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gs_sweep_scheduler.md
Name: gs_sweep_scheduler

Overview:
- Sequences the single-row Gauss-Seidel core across an 8-unknown system (8 rows, 7 off-diagonal coefficients per row) for a fixed number of sweeps.
- Stores the coefficient rows and the solution vector, issues one row at a time to the core, and writes each result back in place so later rows use updated values.
- After the final sweep, streams the 8 solution words out.
- Sits between the host load/unload interface and one core instance.

Parameters:
- N_ITER, 16, sweeps over all 8 rows before output (1..255).
- TIMEOUT, 63, max cycles waiting for core_done per row before abort.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_row_valid  in  1  host row-load strobe
- o_row_ready  out  1  scheduler accepts rows (high only in LOAD)
- i_row_a  in  56  7 x S7 off-diagonal coefficients, ascending column order excluding the diagonal, MSB-first
- i_row_b  in  8  S7 right-hand side
- i_row_adown  in  32  reciprocal of the diagonal, as consumed by the core
- core_clear  out  1  one-cycle pulse returning the core to idle
- core_valid  out  1  one-cycle start strobe to the core
- core_a  out  56  row coefficients
- core_b  out  8  row RHS
- core_adown  out  32  row reciprocal
- core_x  out  224  7 x S7.24 current x values excluding x_k, ascending index, MSB-first
- core_done  in  1  core result valid (level, sticky until core_clear)
- core_xnext  in  32  S7.24 result for row k
- o_valid  out  1  output word valid
- i_ready  in  1  host accepts output word
- o_x  out  32  solution word
- o_idx  out  3  index of o_x
- o_busy  out  1  high in any state except LOAD
- o_error  out  1  sticky timeout flag; cleared by reset only

Behaviour:
- Reset: all outputs 0, except o_row_ready=1. State=LOAD, row count=0, k=0, sweep=0, x[0..7]=0, o_error=0.
- LOAD:
  - A row is accepted on i_row_valid & o_row_ready and stored at row count, which then increments.
  - The 8th accepted row also zeroes x[0..7] and moves to CLEAR the next cycle.
- CLEAR: core_clear=1 for exactly 1 cycle -> ISSUE.
- ISSUE:
  - core_valid=1 for exactly 1 cycle.
  - core_a/b/adown/x are driven from row k and are held stable from ISSUE until leaving WAIT.
  - Next state is WAIT; the timeout counter is zeroed.
- WAIT:
  - Timeout counter increments each cycle.
  - core_done=1: x[k]<=core_xnext in the same edge, then advance:
    - k<7: k++, go to CLEAR.
    - k==7 and sweep<N_ITER-1: k=0, sweep++, go to CLEAR.
    - otherwise: go to OUT with output index=0.
  - Counter reaches TIMEOUT with core_done low: o_error=1, go to OUT with current x contents (partial result).
  - core_done wins if it coincides with the timeout count.
- Gauss-Seidel ordering: core_x for row k is built from the x registers at ISSUE time, so rows 0..k-1 of the current sweep are already updated.
- OUT:
  - o_valid=1, o_x=x[idx], o_idx=idx.
  - On o_valid & i_ready: idx++. When the word with idx 7 transfers, go to LOAD (o_valid=0, o_row_ready=1 next cycle).
  - o_x and o_idx are held while i_ready=0.
- Row strobes are ignored outside LOAD. core_done outside WAIT is ignored.
- i_reset in any state returns to the reset values on the next edge. core_clear is not pulsed by reset; the first CLEAR after the next load re-initialises the core.
- Per-row latency = 2 + core latency + 1 capture cycle.
- No arithmetic in this block; x values are passed through unmodified at 32 bits.

Test Plan:
- Diagonal system (all a=0, adown=0x4000_0000, b_k=k, N_ITER=1) -> output stream idx 0..7, o_x=k*0x0100_0000, o_error=0.
- Handshake: row load with i_row_valid gaps, then i_ready toggling 1/0 during OUT -> every stalled word is held stable, exactly 8 transfers, then back to LOAD.
- Ordering: in sweep 0 row 1, inspect core_x -> slot 0 equals the x[0] captured from row 0 (0x0100_0000 with b_0=1, a=0), not 0.
- Core model that never asserts done -> after TIMEOUT+1 WAIT cycles o_error=1, OUT streams x (row 0 = 0), o_error persists until reset.
- Reset asserted mid-WAIT in sweep 3 -> next cycle state=LOAD, o_busy=0, o_row_ready=1, all x regs 0.
- N_ITER=16 with a core model of fixed 10-cycle latency -> exactly 128 core_valid pulses and 128 core_clear pulses before the first o_valid.
